// File: rtl/sb_pkg.sv
// Shared constants for the result write-back path and the scoreboard.
package sb_pkg;

  localparam int unsigned NUM_FUS    = 4;
  localparam int unsigned REG_BITS   = 5;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned FU_IDX_W   = 2;

  // Functional-unit slot numbers; bit position in fu_req/fu_gnt
  localparam int unsigned FU_ALU0 = 0;
  localparam int unsigned FU_ALU1 = 1;
  localparam int unsigned FU_MUL  = 2;
  localparam int unsigned FU_DIV  = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MUL = 3'd5,
    OP_DIV = 3'd6,
    OP_NOP = 3'd7
  } op_e;

endpackage

// File: rtl/result_bus_arbiter_rr_pick.sv
// Round-robin picker: first set bit of eligible at or above rr_ptr, wrapping to 0.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int p;

  // Scan from the farthest offset down so the nearest eligible FU is written last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    p     = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      p = int'(rr_ptr) + k;
      if (p >= int'(N)) p = p - int'(N);
      if (eligible[p]) begin
        grant    = '0;
        grant[p] = 1'b1;
        idx      = IW'(p);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_bus_arbiter.sv
// Result write-back arbiter: round-robin grant among FUs, one registered write per cycle.
// Optional conflict counter enabled by defining RESULT_BUS_ARB_STATS_EN.
module result_bus_arbiter
  import sb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = sb_pkg::DATA_WIDTH,
  parameter int unsigned NUM_FUS    = sb_pkg::NUM_FUS,
  parameter int unsigned REG_BITS   = sb_pkg::REG_BITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_FUS-1:0]             fu_req,
  input  logic [NUM_FUS*REG_BITS-1:0]    fu_dest,
  input  logic [NUM_FUS*DATA_WIDTH-1:0]  fu_data,
  input  logic [NUM_FUS-1:0]             war_block,
  input  logic                           wb_stall,
  output logic [NUM_FUS-1:0]             fu_gnt,
  output logic                           wb_valid,
  output logic [REG_BITS-1:0]            wb_dest,
  output logic [DATA_WIDTH-1:0]          wb_data,
  output logic [FU_IDX_W-1:0]            wb_fu
`ifdef RESULT_BUS_ARB_STATS_EN
  ,
  output logic [15:0]                    conflict_cnt
`endif
);

  localparam int unsigned PTR_W = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;

  logic [NUM_FUS-1:0]    eligible;
  logic [NUM_FUS-1:0]    pick_gnt;
  logic [PTR_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      rr_ptr_next;
  logic [REG_BITS-1:0]   sel_dest;
  logic [DATA_WIDTH-1:0] sel_data;

  // Stall overrides everything; WAR hold only masks the request, it is not consumed.
  always_comb begin
    eligible = '0;
    if (!wb_stall) eligible = fu_req & ~war_block;
  end

  rr_pick #(
    .N  (NUM_FUS),
    .IW (PTR_W)
  ) u_rr_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .grant    (pick_gnt),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  // Grant is held low throughout reset so no FU retires a result that will be dropped.
  always_comb begin
    fu_gnt = '0;
    if (rst_n) fu_gnt = pick_gnt;
  end

  // One-hot AND-OR mux of the granted FU's payload.
  always_comb begin
    sel_dest = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_FUS; i++) begin
      if (pick_gnt[i]) begin
        sel_dest = sel_dest | fu_dest[i*REG_BITS +: REG_BITS];
        sel_data = sel_data | fu_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr;
    if (pick_any) begin
      if (pick_idx == PTR_W'(NUM_FUS - 1)) rr_ptr_next = '0;
      else                                 rr_ptr_next = pick_idx + PTR_W'(1);
    end
  end

  // Write-back register: payload updates only on a grant, strobe every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_dest  <= '0;
      wb_data  <= '0;
      wb_fu    <= '0;
      rr_ptr   <= '0;
    end else begin
      wb_valid <= pick_any;
      rr_ptr   <= rr_ptr_next;
      if (pick_any) begin
        wb_dest <= sel_dest;
        wb_data <= sel_data;
        wb_fu   <= FU_IDX_W'(pick_idx);
      end
    end
  end

`ifdef RESULT_BUS_ARB_STATS_EN
  // Cycles where two or more FUs competed for the bus, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (($countones(eligible) >= 2) && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/result_bus_arbiter.md
RESULT_BUS_ARBITER -- requirements
Module: result_bus_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, result data width.
REQ-002 SHALL have parameter NUM_FUS, default 4, number of functional units (FU0/FU1 ALU, FU2 MUL, FU3 DIV).
REQ-003 SHALL have parameter REG_BITS, default 5, register index width.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port fu_req  input  NUM_FUS  per-FU result-ready request.
REQ-007 SHALL have port fu_dest  input  NUM_FUS*REG_BITS  packed destination register per FU, FU0 in LSBs.
REQ-008 SHALL have port fu_data  input  NUM_FUS*DATA_WIDTH  packed result per FU, FU0 in LSBs.
REQ-009 SHALL have port war_block  input  NUM_FUS  scoreboard WAR hold; 1 = FU must not write back this cycle.
REQ-010 SHALL have port wb_stall  input  1  register-file busy; 1 = no grant this cycle.
REQ-011 SHALL have port fu_gnt  output  NUM_FUS  one-hot grant, combinational, zero or one bit set.
REQ-012 SHALL have port wb_valid  output  1  registered write-back strobe.
REQ-013 SHALL have port wb_dest  output  REG_BITS  registered write-back register index.
REQ-014 SHALL have port wb_data  output  DATA_WIDTH  registered write-back data.
REQ-015 SHALL have port wb_fu  output  2  index of the FU that produced wb_data (sized for NUM_FUS=4).

Function
REQ-016 SHALL compute eligible = fu_req & ~war_block, and force eligible to 0 while wb_stall=1.
REQ-017 SHALL assert fu_gnt for the first eligible FU found by searching upward from rr_ptr with wrap-around from NUM_FUS-1 to 0.
REQ-018 SHALL keep fu_gnt at 0 when no FU is eligible.
REQ-019 Handshake: FU holds fu_req/dest/data stable until it samples fu_gnt=1 at a rising edge; that edge completes the transfer, and the FU deasserts fu_req or presents its next result in the following cycle.
REQ-020 On a grant edge, SHALL register wb_valid=1, wb_dest, wb_data and wb_fu of the granted FU, so latency from grant to wb_valid is 1 cycle.
REQ-021 On an edge with no grant, SHALL register wb_valid=0 and hold wb_dest, wb_data and wb_fu at their previous values.
REQ-022 On a grant to FU g, SHALL update rr_ptr to (g+1) mod NUM_FUS; with no grant, rr_ptr holds.
REQ-023 SHALL guarantee that a continuously eligible FU is granted within NUM_FUS grant cycles.
REQ-024 A war_block rising while fu_req is high SHALL withhold the grant with no loss of the request; the grant resumes once war_block falls.
REQ-025 wb_stall SHALL take precedence over all requests; no grant and no rr_ptr change occur while it is high.

Reset
REQ-026 On rst_n=0, SHALL immediately set wb_valid=0, wb_dest=0, wb_data=0, wb_fu=0, rr_ptr=0 (and conflict_cnt=0 when compiled in).
REQ-027 fu_gnt SHALL be 0 while rst_n=0; reset mid-transfer SHALL discard the in-flight result.

Configuration
REQ-028 With macro RESULT_BUS_ARB_STATS_EN defined, SHALL add output conflict_cnt (16 bits), incremented on every cycle in which popcount(eligible) >= 2 and saturating at 16'hFFFF.
REQ-029 Without RESULT_BUS_ARB_STATS_EN, the conflict_cnt port and its counter SHALL NOT exist; all other behaviour is identical.

Structure
REQ-030 Package sb_pkg SHALL hold NUM_FUS, REG_BITS, DATA_WIDTH, the FU index constants (FU_ALU0=0, FU_ALU1=1, FU_MUL=2, FU_DIV=3) and op codes, shared with the scoreboard.
REQ-031 The round-robin search SHALL be a combinational sub-module rr_pick (inputs eligible and rr_ptr; outputs grant one-hot, grant index, any).

Verification
REQ-032 Single request: fu_req=0010, fu_dest[1]=7, data=32'hA5A5A5A5 -> fu_gnt=0010 same cycle; next cycle wb_valid=1, wb_dest=7, wb_data=A5A5A5A5, wb_fu=1; rr_ptr=2.
REQ-033 All four request continuously from reset -> grants FU0,FU1,FU2,FU3,FU0 on consecutive cycles; conflict_cnt=4 after those four grant cycles if compiled in.
REQ-034 WAR hold: fu_req=1000, war_block=1000 for 5 cycles -> fu_gnt=0 and wb_valid=0 for those cycles; war_block=0 -> fu_gnt=1000 in that cycle, wb_valid one cycle later.
REQ-035 wb_stall=1 for 3 cycles with fu_req=0101 -> no grants and rr_ptr unchanged; stall released -> FU0 granted, then FU2.
REQ-036 Reset mid-operation: assert rst_n=0 between edges while fu_gnt=0100 -> wb_valid=0 and fu_gnt=0 immediately; after release, rr_ptr=0 so FU0 wins with fu_req=0101.
